sha_round_sequencer: RTL and testbench

SHA_ROUND_SEQUENCER -- requirements
Module: sha_round_sequencer

---
 rtl/sha_pkg.sv | 9 +
 rtl/round_counter.sv | 21 ++
 rtl/sha_round_sequencer.sv | 68 ++++++
 tb/tb_sha_round_sequencer.sv | 125 ++++++++++++
 4 files changed

// File: rtl/sha_pkg.sv
// sha_pkg: shared FSM state type, phase encodings and default sizing for the SHA round sequencer
package sha_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, ROUND, ADD, RESULT} state_t;
    localparam logic [1:0] PH_CHUNK1 = 2'd0;
    localparam logic [1:0] PH_CHUNK2 = 2'd1;
    localparam logic [1:0] PH_HASH2 = 2'd2;
    localparam int DEF_ROUNDS = 64;
    localparam int DEF_PHASES = 3;
endpackage

// File: rtl/round_counter.sv
// round_counter: 6-bit round index with synchronous clear, enable and last-round flag
// Ports: clk, n_rst (async active-low), clear, en in; count[5:0], last out.
module round_counter #(
    parameter int ROUNDS = sha_pkg::DEF_ROUNDS
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clear,
    input  logic       en,
    output logic [5:0] count,
    output logic       last
);
    assign last = count == 6'(ROUNDS - 1);
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (en)
            count <= last ? '0 : count + 6'd1;
endmodule

// File: rtl/sha_round_sequencer.sv
// sha_round_sequencer: Moore FSM stepping a SHA-256 datapath through PHASES compressions of ROUNDS rounds
// Ports: clk, n_rst (async active-low); job_valid/job_ready in/out, abort in;
//        load_w, round_en, round_idx[5:0], phase[1:0], add_hash out; res_valid/res_ready out/in; busy out.
module sha_round_sequencer
    import sha_pkg::*;
#(
    parameter int ROUNDS = DEF_ROUNDS,
    parameter int PHASES = DEF_PHASES
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       job_valid,
    output logic       job_ready,
    input  logic       abort,
    output logic       load_w,
    output logic       round_en,
    output logic [5:0] round_idx,
    output logic [1:0] phase,
    output logic       add_hash,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       busy
);
    localparam logic [1:0] LAST_PH = PHASES == 1 ? PH_CHUNK1 : PHASES == 2 ? PH_CHUNK2 : PH_HASH2;
    state_t state;
    logic last;
    assign job_ready = state == IDLE;
    assign load_w = state == LOAD;
    assign round_en = state == ROUND;
    assign add_hash = state == ADD;
    assign res_valid = state == RESULT;
    assign busy = state != IDLE;
    // Counter is held at zero outside ROUND so round_idx reads 0 there without extra muxing.
    round_counter #(.ROUNDS(ROUNDS)) u_cnt (
        .clk(clk),
        .n_rst(n_rst),
        .clear(abort || state != ROUND),
        .en(round_en),
        .count(round_idx),
        .last(last)
    );
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            state <= IDLE;
            phase <= PH_CHUNK1;
        end else if (abort) begin
            state <= IDLE;
            phase <= PH_CHUNK1;
        end else
            case (state)
                IDLE: if (job_valid) begin
                    state <= LOAD;
                    phase <= PH_CHUNK1;
                end
                LOAD: state <= ROUND;
                ROUND: if (last) state <= ADD;
                ADD: if (phase == LAST_PH) state <= RESULT;
                    else begin
                        state <= LOAD;
                        phase <= phase + 2'd1;
                    end
                RESULT: if (res_ready) begin
                    state <= IDLE;
                    phase <= PH_CHUNK1;
                end
                default: state <= IDLE;
            endcase
endmodule

// File: tb/tb_sha_round_sequencer.sv
// tb_sha_round_sequencer: directed plus random stimulus against an elapsed-cycle reference model
module tb_sha_round_sequencer;
    logic clk = 0, n_rst = 0, job_valid = 0, abort = 0, res_ready = 0;
    always #5 clk = ~clk;
    logic [1:0] job_ready, load_w, round_en, add_hash, res_valid, busy;
    logic [5:0] round_idx [2];
    logic [1:0] phase [2];
    int rounds [2] = '{64, 4};
    int phases [2] = '{3, 1};
    bit act [2] = '{0, 0};
    int el [2] = '{0, 0};
    int n_cmp = 0, n_bad = 0, cyc = 0;

    sha_round_sequencer #(.ROUNDS(64), .PHASES(3)) u_big (
        .clk(clk), .n_rst(n_rst), .job_valid(job_valid), .job_ready(job_ready[0]), .abort(abort),
        .load_w(load_w[0]), .round_en(round_en[0]), .round_idx(round_idx[0]), .phase(phase[0]),
        .add_hash(add_hash[0]), .res_valid(res_valid[0]), .res_ready(res_ready), .busy(busy[0])
    );
    sha_round_sequencer #(.ROUNDS(4), .PHASES(1)) u_small (
        .clk(clk), .n_rst(n_rst), .job_valid(job_valid), .job_ready(job_ready[1]), .abort(abort),
        .load_w(load_w[1]), .round_en(round_en[1]), .round_idx(round_idx[1]), .phase(phase[1]),
        .add_hash(add_hash[1]), .res_valid(res_valid[1]), .res_ready(res_ready), .busy(busy[1])
    );

    task automatic check(string tag, logic [13:0] got, logic [13:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [13:0] obs(int k);
        return {job_ready[k], busy[k], load_w[k], round_en[k], add_hash[k], res_valid[k], phase[k], round_idx[k]};
    endfunction

    // Job timeline: el = edges since acceptance; each phase is LOAD, ROUNDS rounds, ADD.
    function automatic logic [13:0] expect_out(int k);
        int per, o;
        per = rounds[k] + 2;
        if (!act[k]) return {1'b1, 1'b0, 4'b0000, 2'd0, 6'd0};
        if (el[k] == phases[k] * per) return {2'b01, 4'b0001, 2'(phases[k] - 1), 6'd0};
        o = el[k] % per;
        return {2'b01, o == 0, o >= 1 && o <= rounds[k], o == per - 1, 1'b0, 2'(el[k] / per),
                (o >= 1 && o <= rounds[k]) ? 6'(o - 1) : 6'd0};
    endfunction

    task automatic step();
        @(posedge clk);
        for (int k = 0; k < 2; k++)
            if (!n_rst) act[k] = 0;
            else if (!act[k]) begin
                if (job_valid && !abort) begin
                    act[k] = 1;
                    el[k] = 0;
                end
            end else if (abort) act[k] = 0;
            else if (el[k] == phases[k] * (rounds[k] + 2)) begin
                if (res_ready) act[k] = 0;
            end else el[k]++;
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) check($sformatf("dut%0d_outputs", k), obs(k), expect_out(k));
    endtask

    task automatic run_until(int target, int limit);
        int n = 0;
        while (!(act[0] && el[0] == target) && n < limit) begin
            step();
            n++;
        end
        check($sformatf("reach_el_%0d", target), 14'(act[0] && el[0] == target), 14'd1);
    endtask

    initial begin
        #2;
        for (int k = 0; k < 2; k++) check($sformatf("reset%0d", k), obs(k), expect_out(k));
        @(negedge clk);
        n_rst = 1;
        step();
        // single job, then result held without handshake
        job_valid = 1;
        step();
        job_valid = 0;
        run_until(198, 300);
        repeat (10) step();
        res_ready = 1;
        step();
        res_ready = 0;
        step();
        // abort at phase 1, round 30, then immediate new job
        job_valid = 1;
        step();
        job_valid = 0;
        run_until(66 + 31, 200);
        abort = 1;
        step();
        abort = 0;
        job_valid = 1;
        step();
        job_valid = 0;
        // asynchronous reset in phase 2, round 10
        run_until(132 + 11, 300);
        n_rst = 0;
        act = '{0, 0};
        #1;
        for (int k = 0; k < 2; k++) check($sformatf("async_reset%0d", k), obs(k), expect_out(k));
        step();
        n_rst = 1;
        step();
        // back-to-back jobs
        job_valid = 1;
        res_ready = 1;
        repeat (450) step();
        // random traffic
        repeat (4000) begin
            job_valid = 1'($urandom % 2);
            res_ready = ($urandom % 3) == 0;
            abort = ($urandom % 60) == 0;
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
